// File: rtl/pow2_exp_approx_pipe.sv
// Purpose : pipelined 2^x / e^x approximator, 2^(i+f) ~= 2^i * (1+f), signed fixed point.
// Latency : 3 enabled clk edges from accepted input to valid_out.
// Backpressure: none beyond en; en=0 freezes every register, inputs ignored that cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (rst beats en)
//   en              pipeline advance enable
//   valid_in        input sample valid
//   mode_in         0 = 2^x, 1 = e^x (captured per sample)
//   in_x            signed Q(DATA_W-FRAC_W).FRAC_W operand
//   valid_out       result valid
//   pow_in_x        approximate result, same Q format, always >= 0
//   in_x_bypass     original in_x aligned with pow_in_x
//   sat_out         result clamped (overflow, or underflow to 0)
module pow2_exp_approx_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12,
  parameter int LOG2E  = 5909
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              valid_in,
  input  logic              mode_in,
  input  logic [DATA_W-1:0] in_x,
  output logic              valid_out,
  output logic [DATA_W-1:0] pow_in_x,
  output logic [DATA_W-1:0] in_x_bypass,
  output logic              sat_out
);

  localparam int IW = DATA_W - FRAC_W;  // integer bits, including sign
  localparam int PW = 2 * DATA_W;       // scaling product width

  localparam logic signed [PW-1:0]     LOG2E_S = PW'(LOG2E);
  localparam logic        [DATA_W-1:0] Y_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic        [DATA_W-1:0] Y_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  // ---------------- stage 1: optional log2(e) scaling ----------------
  // mode is consumed here; after this stage the sample is fully described by y.
  logic signed [PW-1:0]     x_ext;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     prod_sh;
  logic        [DATA_W:0]   prod_hi;
  logic        [DATA_W-1:0] y1_d;

  logic              v1_q;
  logic [DATA_W-1:0] y1_q;
  logic [DATA_W-1:0] bx1_q;

  always_comb begin
    x_ext   = {{DATA_W{in_x[DATA_W-1]}}, in_x};
    prod    = x_ext * LOG2E_S;
    prod_sh = prod >>> FRAC_W;            // arithmetic shift gives floor
    prod_hi = prod_sh[PW-1:DATA_W-1];     // all-equal means it fits DATA_W signed
    y1_d    = in_x;
    if (mode_in) begin
      if (prod_hi == '0 || prod_hi == '1) begin
        y1_d = prod_sh[DATA_W-1:0];
      end else if (prod_sh[PW-1]) begin
        y1_d = Y_MIN;
      end else begin
        y1_d = Y_MAX;
      end
    end
  end

  // ---------------- stage 2: split into integer / mantissa ----------------
  logic [IW-1:0]     i2_d;
  logic [FRAC_W:0]   m2_d;

  logic              v2_q;
  logic [IW-1:0]     i2_q;
  logic [FRAC_W:0]   m2_q;
  logic [DATA_W-1:0] bx2_q;

  always_comb begin
    i2_d = y1_q[DATA_W-1:FRAC_W];         // signed floor(y / 2^FRAC_W)
    m2_d = {1'b1, y1_q[FRAC_W-1:0]};      // 1 + f
  end

  // ---------------- stage 3: shift and clamp ----------------
  // m lies in [2^FRAC_W, 2^(FRAC_W+1)), so m << i exceeds the positive range
  // exactly when i >= IW-1; below that the shifted value always fits DATA_W bits.
  int                i_s;
  logic [DATA_W-1:0] m_ext;
  logic [DATA_W-1:0] r3_d;
  logic              sat3_d;

  logic              v3_q;
  logic [DATA_W-1:0] r3_q;
  logic [DATA_W-1:0] bx3_q;
  logic              sat3_q;

  always_comb begin
    i_s    = int'($signed(i2_q));
    m_ext  = {{(IW-1){1'b0}}, m2_q};
    r3_d   = '0;
    sat3_d = 1'b0;
    if (i_s >= 0) begin
      if (i_s >= IW - 1) begin
        r3_d   = Y_MAX;
        sat3_d = 1'b1;
      end else begin
        r3_d = m_ext << i_s;
      end
    end else begin
      if (-i_s > FRAC_W) begin
        r3_d   = '0;
        sat3_d = 1'b1;
      end else begin
        r3_d = m_ext >> (-i_s);
      end
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      y1_q   <= '0;
      bx1_q  <= '0;
      v2_q   <= 1'b0;
      i2_q   <= '0;
      m2_q   <= '0;
      bx2_q  <= '0;
      v3_q   <= 1'b0;
      r3_q   <= '0;
      bx3_q  <= '0;
      sat3_q <= 1'b0;
    end else if (en) begin
      v1_q   <= valid_in;
      y1_q   <= y1_d;
      bx1_q  <= in_x;
      v2_q   <= v1_q;
      i2_q   <= i2_d;
      m2_q   <= m2_d;
      bx2_q  <= bx1_q;
      v3_q   <= v2_q;
      r3_q   <= r3_d;
      bx3_q  <= bx2_q;
      sat3_q <= sat3_d;
    end
  end

  assign valid_out   = v3_q;
  assign pow_in_x    = r3_q;
  assign in_x_bypass = bx3_q;
  assign sat_out     = sat3_q;

endmodule

// File: tb/tb_pow2_exp_approx_pipe.sv
// Purpose : self-checking bench for pow2_exp_approx_pipe (default Q4.12 parameters).
// Latency : expects results 3 enabled edges after acceptance.
// Backpressure: exercises en stalls; results tracked through an in-order scoreboard.
module tb_pow2_exp_approx_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid_in;
  logic        mode_in;
  logic [15:0] in_x;
  logic        valid_out;
  logic [15:0] pow_in_x;
  logic [15:0] in_x_bypass;
  logic        sat_out;

  always #5 clk = ~clk;

  pow2_exp_approx_pipe #(
    .DATA_W(16),
    .FRAC_W(12),
    .LOG2E (5909)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .valid_in   (valid_in),
    .mode_in    (mode_in),
    .in_x       (in_x),
    .valid_out  (valid_out),
    .pow_in_x   (pow_in_x),
    .in_x_bypass(in_x_bypass),
    .sat_out    (sat_out)
  );

  typedef struct {
    logic        mode;
    logic [15:0] x;
    logic [15:0] pow;
    logic        sat;
  } vec_t;

  typedef struct packed {
    logic [15:0] pow;
    logic [15:0] x;
    logic        sat;
  } exp_t;

  localparam int NV = 21;
  vec_t vecs[NV];
  exp_t sb[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic adv_q   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at a falling edge; the next rising edge captures them.
  task automatic step(input logic r, input logic e, input logic v, input logic m,
                      input logic [15:0] x, input logic [15:0] ep, input logic es);
    rst      = r;
    en       = e;
    valid_in = v;
    mode_in  = m;
    in_x     = x;
    if (r) sb.delete();
    else if (e && v) sb.push_back('{ep, x, es});
    @(negedge clk);
  endtask

  task automatic apply(input int idx);
    step(1'b0, 1'b1, 1'b1, vecs[idx].mode, vecs[idx].x, vecs[idx].pow, vecs[idx].sat);
  endtask

  task automatic bubble(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic drain_check(input string name);
    bubble(4);
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_valid"},  32'(valid_out),   32'd0);
    chk({tag, "_pow"},    32'(pow_in_x),    32'd0);
    chk({tag, "_bypass"}, 32'(in_x_bypass), 32'd0);
    chk({tag, "_sat"},    32'(sat_out),     32'd0);
  endtask

  // Sample accepted on the first edge must show valid_out only after the third.
  task automatic lat_test(input int idx, input string tag);
    apply(idx);
    chk({tag, "_e1"}, 32'(valid_out), 32'd0);
    bubble(1);
    chk({tag, "_e2"}, 32'(valid_out), 32'd0);
    bubble(1);
    chk({tag, "_e3"}, 32'(valid_out), 32'd1);
    bubble(1);
    chk({tag, "_e4"}, 32'(valid_out), 32'd0);
  endtask

  // A result is new only if the preceding rising edge actually advanced the pipe.
  always @(posedge clk) adv_q <= en && !rst;

  always @(negedge clk) begin
    exp_t e;
    if (adv_q && valid_out) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", 32'(valid_out), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_pow",    32'(pow_in_x),    32'(e.pow));
        chk("sb_bypass", 32'(in_x_bypass), 32'(e.x));
        chk("sb_sat",    32'(sat_out),     32'(e.sat));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    //                mode  x         pow       sat
    vecs[0]  = '{1'b0, 16'h0000, 16'h1000, 1'b0};
    vecs[1]  = '{1'b0, 16'hC000, 16'h0100, 1'b0};
    vecs[2]  = '{1'b0, 16'hF800, 16'h0C00, 1'b0};
    vecs[3]  = '{1'b0, 16'h2800, 16'h6000, 1'b0};
    vecs[4]  = '{1'b0, 16'h1C00, 16'h3800, 1'b0};
    vecs[5]  = '{1'b0, 16'h3000, 16'h7FFF, 1'b1};
    vecs[6]  = '{1'b0, 16'h7FFF, 16'h7FFF, 1'b1};
    vecs[7]  = '{1'b1, 16'h1000, 16'h2E2A, 1'b0};
    vecs[8]  = '{1'b1, 16'h0000, 16'h1000, 1'b0};
    vecs[9]  = '{1'b0, 16'h1000, 16'h2000, 1'b0};
    vecs[10] = '{1'b1, 16'h1000, 16'h2E2A, 1'b0};
    vecs[11] = '{1'b0, 16'hF000, 16'h0800, 1'b0};
    vecs[12] = '{1'b1, 16'hF000, 16'h063A, 1'b0};
    vecs[13] = '{1'b0, 16'h0800, 16'h1800, 1'b0};
    vecs[14] = '{1'b1, 16'h0800, 16'h1B8A, 1'b0};
    vecs[15] = '{1'b1, 16'hFFFF, 16'h0FFF, 1'b0};
    vecs[16] = '{1'b0, 16'h8000, 16'h0010, 1'b0};
    vecs[17] = '{1'b1, 16'h8000, 16'h0010, 1'b0};
    vecs[18] = '{1'b1, 16'h7FFF, 16'h7FFF, 1'b1};
    vecs[19] = '{1'b0, 16'h2FFF, 16'h7FFC, 1'b0};
    vecs[20] = '{1'b0, 16'hE000, 16'h0400, 1'b0};

    rst      = 1'b1;
    en       = 1'b0;
    valid_in = 1'b0;
    mode_in  = 1'b0;
    in_x     = 16'h0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b0);
    // rst with en=1 and a valid input: reset must win
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, 16'h0, 1'b0);
    zero_check("reset");

    lat_test(0, "latency");
    drain_check("latency_drain");

    // back-to-back sweep, including mode interleaving in entries 9..14
    for (int i = 1; i < NV; i++) apply(i);
    drain_check("sweep_drain");

    // stall with two samples in flight and one at the output
    apply(3);
    apply(4);
    apply(7);
    for (int s = 0; s < 4; s++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h0, 1'b0);
      chk("stall_valid",  32'(valid_out),   32'd1);
      chk("stall_pow",    32'(pow_in_x),    32'(vecs[3].pow));
      chk("stall_bypass", 32'(in_x_bypass), 32'(vecs[3].x));
      chk("stall_sat",    32'(sat_out),     32'(vecs[3].sat));
    end
    drain_check("stall_drain");

    // reset with two samples in flight
    apply(9);
    apply(12);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b0);
    zero_check("midrst");
    for (int s = 0; s < 3; s++) begin
      bubble(1);
      chk("midrst_no_valid", 32'(valid_out), 32'd0);
    end
    lat_test(14, "post_rst_lat");
    drain_check("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pow2_exp_approx_pipe.md
Name: pow2_exp_approx_pipe

Overview:
- Parametrised, pipelined successor to the single-mode stage-3 power-of-two approximator in the softmax datapath.
- Computes 2^x, or e^x via log2(e) pre-scaling, selectable per sample. Uses the piecewise-linear approximation 2^(i+f) ≈ 2^i·(1+f) on signed fixed-point data.
- Carries a valid bit, a global stall enable, a per-sample saturation flag and an aligned input bypass, so downstream stages can pair each result with its original operand.

Parameters:
- DATA_W, 16, total signed data width (input and output).
- FRAC_W, 12, fractional bits; default format is Q4.12.
- LOG2E, 5909, log2(e) in unsigned Q(DATA_W-FRAC_W).FRAC_W, round(1.4426950409·2^FRAC_W); default is for FRAC_W=12.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  pipeline advance enable; 0 freezes every pipeline register.
- valid_in  in  1  input sample valid.
- mode_in  in  1  0 = 2^x, 1 = e^x; captured per sample.
- in_x  in  DATA_W  signed input, Q(DATA_W-FRAC_W).FRAC_W.
- valid_out  out  1  output sample valid.
- pow_in_x  out  DATA_W  approximate result, same Q format, always ≥ 0.
- in_x_bypass  out  DATA_W  original in_x, aligned with pow_in_x.
- sat_out  out  1  result was clamped (overflow, or underflow to 0).

Behaviour:
- Reset: one clk edge with rst=1 sets valid_out=0, pow_in_x=0, in_x_bypass=0, sat_out=0 and all internal stage valids to 0.
  - rst has priority over en.
  - rst mid-stream discards all in-flight samples; no valid_out is produced for them.
- Pipeline: 3 register stages. A sample accepted on edge k (en=1, valid_in=1) appears with valid_out=1 after edge k+2, i.e. latency 3 enabled edges.
  - en=0: every stage register, including valid bits and outputs, holds its value. Inputs are ignored that cycle.
  - valid_in=0 with en=1: a bubble propagates (stage valid=0). Data registers may update, but their contents are don't-care while valid=0.
  - Throughput: 1 sample per enabled cycle; no backpressure beyond en.
- Stage 1 (scale):
  - mode=0: y = x.
  - mode=1: p = x·LOG2E, a signed 2·DATA_W product; y = p >>> FRAC_W (arithmetic, floor).
  - y is saturated to the signed DATA_W range. Saturation at this stage alone does not set sat_out.
- Stage 2 (split):
  - i = y >>> FRAC_W (signed floor); f = y[FRAC_W-1:0].
  - m = 2^FRAC_W + f, unsigned FRAC_W+1 bits.
- Stage 3 (shift/clamp):
  - i ≥ 0: r = m << i, computed wide.
    - If r > 2^(DATA_W-1)-1: pow_in_x = 2^(DATA_W-1)-1 and sat_out=1.
    - Else pow_in_x = r, sat_out=0.
  - i < 0: r = m >> (-i), truncating.
    - If -i > FRAC_W: pow_in_x = 0 and sat_out=1.
    - Else pow_in_x = r, sat_out=0.
- in_x_bypass and mode travel alongside their sample through all stages.
- sat_out is meaningful only when valid_out=1.

Test Plan:
- Reset and latency: after rst, drive valid_in=1, mode=0, in_x=0x0000 for one cycle with en=1. Require valid_out=1 exactly 3 edges later, pow_in_x=0x1000, in_x_bypass=0x0000, sat_out=0, and valid_out=0 on the following cycle.
- Mode-0 sweep, back-to-back, one sample per cycle; each result must keep input order and its bypass value:
  - 0xC000 (-4) -> 0x0100
  - 0xF800 (-0.5) -> 0x0C00
  - 0x2800 (2.5) -> 0x6000
  - 0x1C00 (1.75) -> 0x3800
- Overflow: mode 0, in_x=0x3000 (3.0) -> pow_in_x=0x7FFF, sat_out=1. Then in_x=0x7FFF -> 0x7FFF, sat_out=1.
- Mode 1, e^x:
  - in_x=0x1000 -> stage-1 y=0x1715, pow_in_x=0x2E2A, sat_out=0.
  - in_x=0x0000 -> 0x1000.
  - Interleaving mode 0 and mode 1 on consecutive cycles must give each sample its own mode.
- Stall: issue 3 samples, then hold en=0 for 4 cycles mid-flight. Outputs and valid_out must stay frozen and valid_in pulses during the stall must be ignored. After en=1, the remaining results emerge in order with no loss or duplication.
- Reset mid-operation: assert rst with 2 samples in flight. Require no valid_out for them afterwards, all outputs 0, and the next accepted sample to emerge with correct latency 3.
